rd_fifo_space_ctrl: RTL and testbench

RD_FIFO_SPACE_CTRL -- requirements
Module: rd_fifo_space_ctrl

---
 rtl/vdma_ctrl_pkg.sv | 47 ++++
 rtl/rd_fifo_space_ctrl_if.sv | 28 ++
 rtl/rd_space_qual.sv | 40 ++++
 rtl/rd_fifo_space_ctrl.sv | 137 +++++++++++++
 tb/tb_rd_fifo_space_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vdma_ctrl_pkg.sv
// Shared constants and types for the VDMA read- and write-side FIFO controllers.
package vdma_ctrl_pkg;

  localparam int unsigned RD_THRESHOLD = 200;
  localparam int unsigned RD_DEPTH     = 512;
  localparam int unsigned RD_LSIZE     = 9;
  localparam int unsigned RD_FSIZE     = 24;
  localparam int unsigned RD_CNT_W     = 10;
  localparam int unsigned RD_SPACE_W   = 11;

  // Write-side controller drains the FIFO in bursts once enough words are buffered.
  localparam int unsigned WR_THRESHOLD = 256;
  localparam int unsigned WR_DEPTH     = 512;
  localparam int unsigned WR_LSIZE     = 9;
  localparam int unsigned WR_FSIZE     = 24;

  typedef enum logic [2:0] {
    RD_IDLE      = 3'd0,
    RD_NEED_RD   = 3'd1,
    RD_TAIL      = 3'd2,
    RD_WAIT_DONE = 3'd3,
    RD_FSH       = 3'd4
  } rd_state_e;

  typedef enum logic [1:0] {
    WR_IDLE      = 2'd0,
    WR_NEED_WR   = 2'd1,
    WR_WAIT_DONE = 2'd2,
    WR_FSH       = 2'd3
  } wr_state_e;

  typedef struct packed {
    logic burst_ok;
    logic tail_ok;
  } rd_qual_t;

  // Free words in the FIFO; an over-reported fill level counts as full.
  function automatic logic [RD_SPACE_W-1:0] fifo_space(input logic [RD_CNT_W-1:0] cnt,
                                                       input int unsigned depth);
    logic [RD_SPACE_W-1:0] cnt_w;
    logic [RD_SPACE_W-1:0] dep_w;
    cnt_w = RD_SPACE_W'(cnt);
    dep_w = RD_SPACE_W'(depth);
    return (cnt_w > dep_w) ? '0 : (dep_w - cnt_w);
  endfunction

endpackage

// File: rtl/rd_fifo_space_ctrl_if.sv
// Read-request handshake between the FIFO space controller and the AXI read master.
interface rd_fifo_space_ctrl_if #(
  parameter int unsigned LSIZE = vdma_ctrl_pkg::RD_LSIZE
) ();

  logic             burst_req;
  logic             tail_req;
  logic [LSIZE-1:0] req_len;
  logic             resp;
  logic             done;

  modport master (
    output burst_req,
    output tail_req,
    output req_len,
    input  resp,
    input  done
  );

  modport slave (
    input  burst_req,
    input  tail_req,
    input  req_len,
    output resp,
    output done
  );

endinterface

// File: rtl/rd_space_qual.sv
// Computes free FIFO space and registers the burst/tail issue qualifiers each cycle.
module rd_space_qual
  import vdma_ctrl_pkg::*;
#(
  parameter int unsigned THRESHOLD = RD_THRESHOLD,
  parameter int unsigned DEPTH     = RD_DEPTH,
  parameter int unsigned FSIZE     = RD_FSIZE
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic [RD_CNT_W-1:0] count,
  input  logic [FSIZE-1:0]    remain,
  output rd_qual_t            qual_q
);

  localparam logic [RD_SPACE_W-1:0] THR_SP = RD_SPACE_W'(THRESHOLD);
  localparam logic [FSIZE-1:0]      THR_RM = FSIZE'(THRESHOLD);

  logic [RD_SPACE_W-1:0] space_c;
  logic [FSIZE-1:0]      space_ext_c;
  rd_qual_t              qual_d;

  // Burst and tail windows are split at THRESHOLD, so at most one flag is ever set.
  always_comb begin
    space_c          = fifo_space(count, DEPTH);
    space_ext_c      = FSIZE'(space_c);
    qual_d           = '0;
    qual_d.burst_ok  = (space_c >= THR_SP) && (remain >= THR_RM);
    qual_d.tail_ok   = (remain != '0) && (remain < THR_RM) && (space_ext_c >= remain);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      qual_q <= '0;
    end else begin
      qual_q <= qual_d;
    end
  end

endmodule

// File: rtl/rd_fifo_space_ctrl.sv
// Read-side FIFO space controller: splits a frame into THRESHOLD-word bursts plus a
// short tail, issuing each request only once the FIFO has room for all of its data.
module rd_fifo_space_ctrl
  import vdma_ctrl_pkg::*;
#(
  parameter int unsigned THRESHOLD = RD_THRESHOLD,
  parameter int unsigned DEPTH     = RD_DEPTH,
  parameter int unsigned LSIZE     = RD_LSIZE,
  parameter int unsigned FSIZE     = RD_FSIZE
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic [RD_CNT_W-1:0]  count,
  input  logic                 frame_start,
  input  logic [FSIZE-1:0]     frame_words,
  output logic                 busy,
  output logic                 frame_done,
  rd_fifo_space_ctrl_if.master rd_if
);

  localparam logic [LSIZE-1:0] BURST_LEN = LSIZE'(THRESHOLD);

  rd_state_e        state_q,      state_d;
  logic             busy_q,       busy_d;
  logic [FSIZE-1:0] remain_q,     remain_d;
  logic             burst_req_q,  burst_req_d;
  logic             tail_req_q,   tail_req_d;
  logic [LSIZE-1:0] req_len_q,    req_len_d;
  logic             frame_done_q, frame_done_d;
  logic             start_acc_c;
  logic             issuing_c;
  rd_qual_t         qual;

  rd_space_qual #(
    .THRESHOLD (THRESHOLD),
    .DEPTH     (DEPTH),
    .FSIZE     (FSIZE)
  ) u_qual (
    .clock  (clock),
    .rst_n  (rst_n),
    .count  (count),
    .remain (remain_q),
    .qual_q (qual)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RD_IDLE;
      busy_q       <= 1'b0;
      remain_q     <= '0;
      burst_req_q  <= 1'b0;
      tail_req_q   <= 1'b0;
      req_len_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      remain_q     <= remain_d;
      burst_req_q  <= burst_req_d;
      tail_req_q   <= tail_req_d;
      req_len_q    <= req_len_d;
      frame_done_q <= frame_done_d;
    end
  end

  // done is ignored while a request is pending, even when it coincides with resp.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RD_IDLE: begin
        if (busy_q && qual.tail_ok) begin
          state_d = RD_TAIL;
        end else if (busy_q && qual.burst_ok) begin
          state_d = RD_NEED_RD;
        end
      end
      RD_NEED_RD, RD_TAIL: begin
        if (rd_if.resp) begin
          state_d = RD_WAIT_DONE;
        end
      end
      RD_WAIT_DONE: begin
        if (rd_if.done) begin
          state_d = RD_FSH;
        end
      end
      RD_FSH:  state_d = RD_IDLE;
      default: state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    start_acc_c  = frame_start && !busy_q && (frame_words != '0);
    issuing_c    = (state_q == RD_NEED_RD) || (state_q == RD_TAIL);
    busy_d       = busy_q;
    remain_d     = remain_q;
    burst_req_d  = 1'b0;
    tail_req_d   = 1'b0;
    req_len_d    = '0;
    frame_done_d = 1'b0;

    if (start_acc_c) begin
      busy_d   = 1'b1;
      remain_d = frame_words;
    end
    if (issuing_c && rd_if.resp) begin
      remain_d = remain_q - FSIZE'(req_len_q);
    end
    // The settle cycle after the last transfer closes the frame.
    if ((state_q == RD_FSH) && (remain_q == '0)) begin
      busy_d = 1'b0;
    end

    burst_req_d  = (state_d == RD_NEED_RD);
    tail_req_d   = (state_d == RD_TAIL);
    frame_done_d = (state_d == RD_FSH) && (remain_d == '0);
    unique case (state_d)
      RD_NEED_RD:   req_len_d = BURST_LEN;
      RD_TAIL:      req_len_d = remain_d[LSIZE-1:0];
      RD_WAIT_DONE: req_len_d = req_len_q;
      default:      req_len_d = '0;
    endcase
  end

  assign busy            = busy_q;
  assign frame_done      = frame_done_q;
  assign rd_if.burst_req = burst_req_q;
  assign rd_if.tail_req  = tail_req_q;
  assign rd_if.req_len   = req_len_q;

  // Request strobes are mutually exclusive and only present with a frame in flight.
  a_req_excl: assert property (@(posedge clock) disable iff (!rst_n)
    !(burst_req_q && tail_req_q));
  a_req_busy: assert property (@(posedge clock) disable iff (!rst_n)
    (burst_req_q || tail_req_q || frame_done_q) |-> busy_q);

endmodule

// File: tb/tb_rd_fifo_space_ctrl.sv
// Bench for rd_fifo_space_ctrl: directed frame scenarios plus randomized traffic,
// all checked every cycle against a transaction-level model of the frame splitter.
module tb_rd_fifo_space_ctrl;
  import vdma_ctrl_pkg::*;

  localparam int TH  = 200;
  localparam int DEP = 512;

  logic        clock       = 1'b0;
  logic        rst_n       = 1'b0;
  logic [9:0]  count       = '0;
  logic        frame_start = 1'b0;
  logic [23:0] frame_words = '0;
  logic        busy;
  logic        frame_done;

  rd_fifo_space_ctrl_if #(.LSIZE(9)) rif ();

  rd_fifo_space_ctrl dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .count       (count),
    .frame_start (frame_start),
    .frame_words (frame_words),
    .busy        (busy),
    .frame_done  (frame_done),
    .rd_if       (rif.master)
  );

  always #5 clock = ~clock;

  int n_cmp      = 0;
  int n_err      = 0;
  int fd_count   = 0;
  int req_cycles = 0;

  // Model: frame progress as remaining words, the outstanding request, and the
  // previous cycle's eligibility (issue decisions see one-cycle-old space/remain).
  bit m_busy;
  int m_remain;
  int m_kind;      // 0 none, 1 burst, 2 tail
  bit m_accepted;
  bit m_settle;
  int m_len;
  bit m_fd;
  bit m_elig_burst;
  bit m_elig_tail;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h want 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int space_of(input int c);
    return (c > DEP) ? 0 : DEP - c;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_remain = 0; m_kind = 0; m_accepted = 0; m_settle = 0;
    m_len = 0; m_fd = 0; m_elig_burst = 0; m_elig_tail = 0;
  endtask

  task automatic model_step();
    int sp;
    bit eb_new;
    bit et_new;
    bit was_busy;
    sp       = space_of(int'(count));
    eb_new   = (sp >= TH) && (m_remain >= TH);
    et_new   = (m_remain != 0) && (m_remain < TH) && (sp >= m_remain);
    was_busy = m_busy;
    if (m_kind != 0) begin
      if (rif.resp) begin
        m_remain   = m_remain - m_len;
        m_kind     = 0;
        m_accepted = 1;
      end
    end else if (m_accepted) begin
      if (rif.done) begin
        m_accepted = 0;
        m_settle   = 1;
        m_len      = 0;
        m_fd       = (m_remain == 0);
      end
    end else if (m_settle) begin
      m_settle = 0;
      m_fd     = 0;
      if (m_remain == 0) m_busy = 0;
    end else if (m_busy) begin
      if (m_elig_tail) begin
        m_kind = 2; m_len = m_remain;
      end else if (m_elig_burst) begin
        m_kind = 1; m_len = TH;
      end
    end
    if (frame_start && !was_busy && (frame_words != 0)) begin
      m_busy   = 1;
      m_remain = int'(frame_words);
    end
    m_elig_burst = eb_new;
    m_elig_tail  = et_new;
  endtask

  initial begin : model
    model_reset();
    forever begin
      @(posedge clock or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  initial begin : compare
    logic [12:0] act_v;
    logic [12:0] exp_v;
    forever begin
      @(negedge clock);
      act_v = {rif.burst_req, rif.tail_req, busy, frame_done, rif.req_len};
      exp_v = {m_kind == 1, m_kind == 2, m_busy, m_fd, 9'(m_len)};
      chk("cycle{burst,tail,busy,fd,len}", longint'(act_v), longint'(exp_v));
      if (frame_done) fd_count++;
      if (rif.burst_req || rif.tail_req) req_cycles++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_frame(input int words);
    frame_words = 24'(words);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_req(input int budget, input string name, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (rif.burst_req || rif.tail_req) ok = 1;
      else tick();
    end
    chk({name, "_seen"}, longint'(ok), 1);
  endtask

  // Wait for a request, accept it, then report its data landed a few cycles later.
  task automatic serve(input int budget, input string name, input int exp_kind, input int exp_len);
    bit ok;
    wait_req(budget, name, ok);
    if (ok) begin
      chk({name, "_kind"}, longint'(rif.tail_req ? 2 : 1), longint'(exp_kind));
      chk({name, "_len"}, longint'(rif.req_len), longint'(exp_len));
      rif.resp = 1'b1; tick(); rif.resp = 1'b0;
      tick(); tick();
      rif.done = 1'b1; tick(); rif.done = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (!busy) ok = 1;
      else tick();
    end
    chk({name, "_idle"}, longint'(ok), 1);
  endtask

  initial begin : main
    bit ok;
    int fd0;
    int rq0;
    rif.resp = 1'b0;
    rif.done = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", longint'({busy, frame_done, rif.burst_req, rif.tail_req, rif.req_len}), 0);
    rst_n = 1'b1;
    tick();

    // 450 words into an empty FIFO, with a second frame_start ignored while busy.
    count = 10'd0;
    fd0 = fd_count;
    start_frame(450);
    chk("s034_busy_set", longint'(busy), 1);
    start_frame(900);
    serve(10, "s034_r1", 1, 200);
    serve(10, "s034_r2", 1, 200);
    serve(10, "s034_r3", 2, 50);
    wait_idle(10, "s034");
    chk("s034_frame_done_count", longint'(fd_count - fd0), 1);

    // Not enough space for a burst until the fill level drops.
    count = 10'd400;
    fd0 = fd_count;
    start_frame(400);
    rq0 = req_cycles;
    repeat (10) tick();
    chk("s035_no_req", longint'(req_cycles - rq0), 0);
    count = 10'd312;
    serve(3, "s035_r1", 1, 200);
    serve(10, "s035_r2", 1, 200);
    wait_idle(10, "s035");
    chk("s035_frame_done_count", longint'(fd_count - fd0), 1);

    // Tail held off until the whole tail fits.
    count = 10'd412;
    fd0 = fd_count;
    start_frame(150);
    rq0 = req_cycles;
    repeat (10) tick();
    chk("s036_no_req", longint'(req_cycles - rq0), 0);
    count = 10'd362;
    serve(5, "s036_tail", 2, 150);
    wait_idle(10, "s036");
    chk("s036_frame_done_count", longint'(fd_count - fd0), 1);

    // resp and done together: done is lost, a later done completes the frame.
    count = 10'd0;
    fd0 = fd_count;
    start_frame(200);
    wait_req(10, "s038", ok);
    rif.resp = 1'b1; rif.done = 1'b1; tick();
    rif.resp = 1'b0; rif.done = 1'b0;
    repeat (5) tick();
    chk("s038_still_busy", longint'(busy), 1);
    chk("s038_no_frame_done", longint'(fd_count - fd0), 0);
    rif.done = 1'b1; tick(); rif.done = 1'b0;
    chk("s038_frame_done_now", longint'(frame_done), 1);
    wait_idle(10, "s038");
    chk("s038_frame_done_count", longint'(fd_count - fd0), 1);

    // Reset while waiting for done abandons the frame.
    fd0 = fd_count;
    start_frame(450);
    wait_req(10, "s039", ok);
    rif.resp = 1'b1; tick(); rif.resp = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("s039_async_zero", longint'({busy, frame_done, rif.burst_req, rif.tail_req, rif.req_len}), 0);
    tick();
    rst_n = 1'b1;
    rif.done = 1'b1; tick(); rif.done = 1'b0;
    repeat (3) tick();
    chk("s039_no_frame_done", longint'(fd_count - fd0), 0);
    start_frame(200);
    serve(10, "s039_r1", 1, 200);
    wait_idle(10, "s039");
    chk("s039_frame_done_count", longint'(fd_count - fd0), 1);

    // Randomized traffic: fill level, handshakes, frame starts and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      count    = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                             : 10'($urandom_range(0, 512));
      rif.resp = ($urandom_range(0, 2) == 0);
      rif.done = ($urandom_range(0, 3) == 0);
      frame_start = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 5))
        0:       frame_words = 24'd0;
        1:       frame_words = 24'(TH);
        2:       frame_words = 24'(TH - 1);
        3:       frame_words = 24'($urandom_range(1, TH - 1));
        4:       frame_words = 24'($urandom_range(TH, 1200));
        default: frame_words = 24'd450;
      endcase
      rst_n = ($urandom_range(0, 399) != 0);
      tick();
    end
    rst_n = 1'b1;
    frame_start = 1'b0;
    rif.resp = 1'b0;
    rif.done = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
